// File: rtl/acc_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// acc_store_pkg
// Shared definitions for the accumulator store unit:
//   - acc_state_e : FSM state encodings (IDLE, WRITE, READ, DONE)
//   - ERR_*       : err_code values reported with the done pulse
// The READ encoding exists in every build. It is only entered when
// ACC_STORE_VERIFY_EN is defined.
// -----------------------------------------------------------------------------
package acc_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_WR_TO    = 2'b01;
    localparam logic [1:0] ERR_RD_TO    = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

endpackage

// File: rtl/acc_store_unit_if.sv
// -----------------------------------------------------------------------------
// acc_store_unit_if
// Data-memory port between the store unit (master) and memory (slave).
//   mem_addr   master->slave  ADDR_W  address of the access
//   mem_wdata  master->slave  DATA_W  write data
//   mem_wr_req master->slave  1       write request
//   mem_rd_req master->slave  1       read request
//   mem_rdata  slave->master  DATA_W  read data, valid with mem_ack during a read
//   mem_ack    slave->master  1       acknowledge
// Handshake: a request stays high, with addr/wdata stable, until the slave
// raises mem_ack. The access completes at the first rising edge where the
// request and mem_ack are both high, and the request drops after that edge.
// The master may also withdraw a request after its own timeout. mem_ack while
// no request is high has no effect. mem_wr_req and mem_rd_req are never high
// at the same time.
// -----------------------------------------------------------------------------
interface acc_store_unit_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr_req;
    logic              mem_rd_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_wr_req, mem_rd_req,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wr_req, mem_rd_req,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/acc_store_unit_wait_timer.sv
// -----------------------------------------------------------------------------
// acc_wait_timer
// Clear/enable wait counter. expire_o is high while the count equals
// TIMEOUT-1. The count holds at that value instead of wrapping.
// Ports:
//   clk_50m   in   system clock
//   reset     in   synchronous, active-high
//   clr_i     in   force count to 0 (has priority over en_i)
//   en_i      in   count one cycle of waiting
//   expire_o  out  count == TIMEOUT-1
// -----------------------------------------------------------------------------
module acc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_50m,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/acc_store_unit.sv
// -----------------------------------------------------------------------------
// acc_store_unit
// Captures the accumulator value on a store command and writes it to data
// memory over a req/ack handshake, with a bounded wait. When the
// ACC_STORE_VERIFY_EN macro is defined, every acknowledged write is followed by
// a read-back of the same address and a compare.
// Ports:
//   clk_50m      in   system clock, posedge
//   reset        in   synchronous, active-high
//   st_start_i   in   store command, accepted only in IDLE
//   st_addr_i    in   store address, sampled with st_start_i
//   acc_in_i     in   accumulator value, sampled with st_start_i
//   busy_o       out  high whenever the FSM is not IDLE
//   done_o       out  one-cycle pulse ending every accepted store
//   err_code_o   out  result code, valid with done_o, held until next accept
//   dbg_state_o  out  current FSM state
//   mem_bus      master modport of acc_store_unit_if
// -----------------------------------------------------------------------------
module acc_store_unit
    import acc_store_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic              st_start_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] acc_in_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_code_o,
    output acc_state_e        dbg_state_o,
    acc_store_unit_if.master  mem_bus
);
    acc_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_req_q;
    logic              done_q;
    logic [1:0]        err_q;
    logic              counting;
    logic              tmr_expire;

`ifdef ACC_STORE_VERIFY_EN
    logic              rd_req_q;

    // The first READ cycle is a bubble with no request high. The read request
    // starts one cycle after the write request drops, and the wait counter
    // starts again from 0 for the read.
    assign counting = (state_q == ST_WRITE) || ((state_q == ST_READ) && rd_req_q);
    assign mem_bus.mem_rd_req = rd_req_q;
`else
    assign counting = (state_q == ST_WRITE);
    assign mem_bus.mem_rd_req = 1'b0;
`endif

    acc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_50m  (clk_50m),
        .reset    (reset),
        .clr_i    (!counting),
        .en_i     (counting && !mem_bus.mem_ack),
        .expire_o (tmr_expire)
    );

    assign mem_bus.mem_addr   = addr_q;
    assign mem_bus.mem_wdata  = data_q;
    assign mem_bus.mem_wr_req = wr_req_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;
    assign err_code_o         = err_q;
    assign dbg_state_o        = state_q;

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            wr_req_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_OK;
`ifdef ACC_STORE_VERIFY_EN
            rd_req_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (st_start_i) begin
                        addr_q   <= st_addr_i;
                        data_q   <= acc_in_i;
                        err_q    <= ERR_OK;
                        wr_req_q <= 1'b1;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // If ack and expiry arrive in the same cycle, the ack wins.
                    if (mem_bus.mem_ack) begin
                        wr_req_q <= 1'b0;
`ifdef ACC_STORE_VERIFY_EN
                        state_q  <= ST_READ;
`else
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
`endif
                    end else if (tmr_expire) begin
                        wr_req_q <= 1'b0;
                        err_q    <= ERR_WR_TO;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end
                end
`ifdef ACC_STORE_VERIFY_EN
                ST_READ: begin
                    if (!rd_req_q) begin
                        rd_req_q <= 1'b1;
                    end else if (mem_bus.mem_ack) begin
                        rd_req_q <= 1'b0;
                        err_q    <= (mem_bus.mem_rdata == data_q) ? ERR_OK : ERR_MISMATCH;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end else if (tmr_expire) begin
                        rd_req_q <= 1'b0;
                        err_q    <= ERR_RD_TO;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_store_unit.sv
// -----------------------------------------------------------------------------
// tb_acc_store_unit
// Directed bench for acc_store_unit. The bench drives and samples on the
// falling edge. A small memory responder raises mem_ack after a programmable
// number of request cycles. A latency of -1 means the responder never
// acknowledges. The bench follows ACC_STORE_VERIFY_EN in the same way as the
// RTL.
// -----------------------------------------------------------------------------
module tb_acc_store_unit;
    import acc_store_pkg::*;

`ifdef ACC_STORE_VERIFY_EN
    localparam int VX = 2;   // extra cycles from the read-back (bubble + read)
    localparam int RDN = 1;  // read requests per acknowledged write
`else
    localparam int VX = 0;
    localparam int RDN = 0;
`endif

    logic        clk_50m = 1'b0;
    logic        reset = 1'b1;
    logic        st_start = 1'b0;
    logic [11:0] st_addr = '0;
    logic [15:0] acc_in = '0;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    acc_state_e  dbg_state;

    acc_store_unit_if #(.ADDR_W(12), .DATA_W(16)) mem_bus ();

    acc_store_unit #(
        .DATA_W  (16),
        .ADDR_W  (12),
        .TIMEOUT (15)
    ) dut (
        .clk_50m     (clk_50m),
        .reset       (reset),
        .st_start_i  (st_start),
        .st_addr_i   (st_addr),
        .acc_in_i    (acc_in),
        .busy_o      (busy),
        .done_o      (done),
        .err_code_o  (err_code),
        .dbg_state_o (dbg_state),
        .mem_bus     (mem_bus)
    );

    // clock
    always #10 clk_50m = ~clk_50m;

    // memory responder
    int          wr_lat = 0;
    int          rd_lat = 0;
    int          req_cnt = 0;
    logic [15:0] rd_value = '0;

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
    end

    always @(negedge clk_50m) begin
        if (mem_bus.mem_wr_req) begin
            mem_bus.mem_ack = (wr_lat >= 0) && (req_cnt == wr_lat);
            req_cnt++;
        end else if (mem_bus.mem_rd_req) begin
            mem_bus.mem_ack   = (rd_lat >= 0) && (req_cnt == rd_lat);
            mem_bus.mem_rdata = rd_value;
            req_cnt++;
        end else begin
            mem_bus.mem_ack = 1'b0;
            req_cnt = 0;
        end
    end

    // scoreboard
    int          n_run = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One store: issues st_start at a falling edge and observes 30 cycles.
    // Cycle k=1 is the cycle after the accept edge. poke_k > 0 raises
    // st_start with different data during cycle poke_k.
    task automatic run_store(input logic [11:0] a, input logic [15:0] d, input int poke_k,
                             output int lat, output int wr_n, output int rd_n, output int dn,
                             output logic busy_ok, output logic bus_ok, output logic [15:0] last_wd);
        exp_q.push_back(d);
        st_addr  = a;
        acc_in   = d;
        st_start = 1'b1;
        @(negedge clk_50m);
        st_start = 1'b0;
        lat = -1; wr_n = 0; rd_n = 0; dn = 0;
        busy_ok = 1'b1; bus_ok = 1'b1; last_wd = 'x;
        for (int k = 1; k <= 30; k++) begin
            if (mem_bus.mem_wr_req === 1'b1) begin
                wr_n++;
                last_wd = mem_bus.mem_wdata;
                if (mem_bus.mem_addr !== a) bus_ok = 1'b0;
            end
            if (mem_bus.mem_rd_req === 1'b1) begin
                rd_n++;
                if (mem_bus.mem_addr !== a) bus_ok = 1'b0;
            end
            if (mem_bus.mem_wr_req === 1'b1 && mem_bus.mem_rd_req === 1'b1) bus_ok = 1'b0;
            if (done === 1'b1) begin
                dn++;
                if (lat < 0) lat = k;
            end
            if (lat < 0 && busy !== 1'b1) busy_ok = 1'b0;
            if (lat > 0 && k == lat + 1 && busy !== 1'b0) busy_ok = 1'b0;
            if (k == poke_k) begin
                st_start = 1'b1;
                acc_in   = 16'h1234;
                st_addr  = 12'hFFF;
            end else begin
                st_start = 1'b0;
            end
            @(negedge clk_50m);
        end
        check_val("wdata_sb", last_wd, exp_q.pop_front());
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err_code, 0);
        check_val({tag, "_wr_req"}, mem_bus.mem_wr_req, 0);
        check_val({tag, "_rd_req"}, mem_bus.mem_rd_req, 0);
        check_val({tag, "_addr"}, mem_bus.mem_addr, 0);
        check_val({tag, "_wdata"}, mem_bus.mem_wdata, 0);
        check_val({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    int          lat, wr_n, rd_n, dn;
    logic        busy_ok, bus_ok;
    logic [15:0] last_wd;
    int          done_seen;

    initial begin
        // reset
        reset = 1'b1;
        repeat (3) @(negedge clk_50m);
        check_idle_outputs("rst");
        reset = 1'b0;
        @(negedge clk_50m);

        // T1: zero-wait ack
        wr_lat = 0; rd_lat = 0; rd_value = 16'hBEEF;
        run_store(12'h010, 16'hBEEF, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t1_lat", lat, 2 + VX);
        check_val("t1_wr_n", wr_n, 1);
        check_val("t1_rd_n", rd_n, RDN);
        check_val("t1_done_n", dn, 1);
        check_val("t1_err", err_code, ERR_OK);
        check_val("t1_busy", busy_ok, 1);
        check_val("t1_bus", bus_ok, 1);

        // T2: ack after 5 wait cycles
        wr_lat = 5; rd_value = 16'hA5A5;
        run_store(12'h123, 16'hA5A5, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t2_wr_n", wr_n, 6);
        check_val("t2_lat", lat, 7 + VX);
        check_val("t2_busy", busy_ok, 1);
        check_val("t2_err", err_code, ERR_OK);
        check_val("t2_bus", bus_ok, 1);

        // T3: no ack -> write timeout after 15 request cycles
        wr_lat = -1;
        run_store(12'h3C0, 16'h0F0F, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t3_wr_n", wr_n, 15);
        check_val("t3_lat", lat, 16);
        check_val("t3_done_n", dn, 1);
        check_val("t3_rd_n", rd_n, 0);
        check_val("t3_err", err_code, ERR_WR_TO);

        // T3b: ack in the last allowed cycle -> the ack wins over the timeout
        wr_lat = 14; rd_value = 16'h5A5A;
        run_store(12'h3C1, 16'h5A5A, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t3b_wr_n", wr_n, 15);
        check_val("t3b_lat", lat, 16 + VX);
        check_val("t3b_err", err_code, ERR_OK);

        // T4: st_start while in WRITE is ignored
        wr_lat = 3; rd_value = 16'hBEEF;
        run_store(12'h010, 16'hBEEF, 2, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t4_done_n", dn, 1);
        check_val("t4_bus", bus_ok, 1);
        check_val("t4_lat", lat, 5 + VX);
        check_val("t4_wr_n", wr_n, 4);

        // T4b: st_start in the DONE cycle is ignored
        wr_lat = 0;
        run_store(12'h011, 16'hBEEF, 2 + VX, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t4b_done_n", dn, 1);
        check_val("t4b_wr_n", wr_n, 1);
        check_val("t4b_bus", bus_ok, 1);

        // T5: reset 2 cycles into WRITE
        wr_lat = -1;
        st_addr = 12'h055; acc_in = 16'h7777; st_start = 1'b1;
        @(negedge clk_50m);
        st_start = 1'b0;
        check_val("t5_wr_req_pre", mem_bus.mem_wr_req, 1);
        @(negedge clk_50m);
        reset = 1'b1;
        @(negedge clk_50m);
        check_idle_outputs("t5");
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50m);
            if (done === 1'b1) done_seen++;
        end
        check_val("t5_no_done", done_seen, 0);
        wr_lat = 0; rd_value = 16'hC0DE;
        run_store(12'h020, 16'hC0DE, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t5_lat", lat, 2 + VX);
        check_val("t5_err", err_code, ERR_OK);
        check_val("t5_bus", bus_ok, 1);

`ifdef ACC_STORE_VERIFY_EN
        // T6: read-back mismatch, match, and read timeout
        wr_lat = 0; rd_lat = 0; rd_value = 16'hBEEE;
        run_store(12'h010, 16'hBEEF, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t6_mis_err", err_code, ERR_MISMATCH);
        check_val("t6_mis_lat", lat, 4);
        check_val("t6_mis_rd_n", rd_n, 1);
        rd_value = 16'hBEEF;
        run_store(12'h010, 16'hBEEF, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t6_ok_err", err_code, ERR_OK);
        check_val("t6_ok_lat", lat, 4);
        check_val("t6_bus", bus_ok, 1);
        rd_lat = -1;
        run_store(12'h010, 16'hBEEF, 0, lat, wr_n, rd_n, dn, busy_ok, bus_ok, last_wd);
        check_val("t6_rto_err", err_code, ERR_RD_TO);
        check_val("t6_rto_rd_n", rd_n, 15);
        check_val("t6_rto_lat", lat, 18);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
